// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter_if
// Brief    : Bundle of the four producer lanes and the single downstream
//            stream handled by mux_rr_arbiter. The master modport is the
//            arbiter side; the slave modport is the producers/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
  parameter int W = 8
);
  logic [3:0]     req;
  logic [4*W-1:0] data;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           dout_ready;
  logic [3:0]     ack;

  modport master (
    input  req,
    input  data,
    input  dout_ready,
    output gnt,
    output sel,
    output dout,
    output dout_valid,
    output ack
  );

  modport slave (
    output req,
    output data,
    output dout_ready,
    input  gnt,
    input  sel,
    input  dout,
    input  dout_valid,
    input  ack
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Round-robin arbiter/sequencer for a 4-input word mux. Grants one
//            lane at a time, drives the mux select and forwards that lane's
//            words over a valid/ready handshake. A grant is released after
//            MAX_HOLD accepted words or when the lane drops its request.
//            Optional macro ARB_FIXED_PRIO_EN: fixed priority (lane 0
//            highest) instead of round-robin; MAX_HOLD release still applies.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4   // legal range 1..15
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mux_rr_arbiter_if.master   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Count value of the last word a grant may carry.
  localparam logic [3:0] C_LAST_CNT = 4'(MAX_HOLD - 1);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;

  state_t     w_state_nxt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] w_sel_nxt;
  logic [1:0] w_ptr_nxt;
  logic [3:0] w_cnt_nxt;

  logic       w_found;
  logic [1:0] w_pick;
  logic       w_dout_valid;
  logic       w_xfer;
  logic [W-1:0] w_lane [4];

  // Unpack the flat data bus into one word per lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = bus.data[gi*W +: W];
  end

  // Stream outputs: valid only while the granted lane still requests, and
  // dout depends on registers/req/data only (never on dout_ready).
  assign w_dout_valid   = (r_state == S_BUSY) && bus.req[r_sel];
  assign w_xfer         = w_dout_valid && bus.dout_ready;
  assign bus.dout_valid = w_dout_valid;
  assign bus.dout       = w_dout_valid ? w_lane[r_sel] : '0;
  assign bus.ack        = r_gnt & {4{w_xfer}};
  assign bus.gnt        = r_gnt;
  assign bus.sel        = r_sel;

  // Pick the first requesting lane scanning ptr, ptr+1, ptr+2, ptr+3; the
  // scan runs backwards so the nearest lane to ptr is written last and wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[r_ptr + i[1:0]]) begin
        w_found = 1'b1;
        w_pick  = r_ptr + i[1:0];
      end
    end
  end

  // Next-state logic: grant from IDLE, count/release while BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
          w_sel_nxt   = w_pick;
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_BUSY: begin
        // A dropped request or the last allowed word both end the grant;
        // sel is left alone so the mux stays put through the IDLE bubble.
        if (!bus.req[r_sel] || (w_xfer && (r_cnt == C_LAST_CNT))) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_cnt_nxt   = 4'd0;
`ifdef ARB_FIXED_PRIO_EN
          w_ptr_nxt   = 2'd0;
`else
          w_ptr_nxt   = r_sel + 2'd1;
`endif
        end else if (w_xfer) begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State registers; reset aborts any in-flight word without acknowledging it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for a 4-input word multiplexer. Four requesters compete for one output stream. The block grants one requester at a time, drives the mux select, and forwards that lane's words over a valid/ready handshake. It sits between four producer lanes and a single downstream consumer, and owns the select that was previously driven statically.

## Interface
- `W`, default 8: data width per lane.
- `MAX_HOLD`, default 4: maximum accepted words per grant before forced release; legal range 1..15.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  4  per-lane request; lane i holds it high while it has a word on its data slice
- `data`  in  4*W  lane i word = `data[i*W +: W]`
- `gnt`  out  4  registered one-hot grant; 0 in IDLE
- `sel`  out  2  registered mux select (index of granted lane)
- `dout`  out  W  selected lane word; forced to 0 when `dout_valid`=0
- `dout_valid`  out  1  `state==BUSY && req[sel]`, combinational
- `dout_ready`  in  1  consumer accepts `dout` this cycle
- `ack`  out  4  combinational: `gnt & {4{dout_valid & dout_ready}}`; one-cycle pulse per accepted word

## Operation
- Registered state: `state` (IDLE/BUSY), `gnt`, `sel`, `ptr[1:0]` (next lane with top priority), `cnt[3:0]` (words accepted in the current grant).
- Reset values: state=IDLE, gnt=0000, sel=00, ptr=00, cnt=0. This gives dout=0, dout_valid=0, and ack=0000.
- **IDLE:**
  - If `req`=0, stay in IDLE.
  - Otherwise, choose the first set `req` bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load `sel`/`gnt` for that lane, set cnt=0, and go to BUSY.
- **BUSY, transfer** (`dout_valid & dout_ready`):
  - `ack[sel]` pulses and cnt increments.
  - If cnt==MAX_HOLD-1 before the increment, release.
- **BUSY, `req[sel]`=0:** release immediately. No transfer occurs that cycle.
- **BUSY, `dout_ready`=0 with `req[sel]`=1:** hold everything. There is no timeout.
- **Release:**
  - state goes to IDLE, gnt=0000, cnt=0.
  - ptr=sel+1 (wraps 3 to 0).
  - sel keeps its value.
- Requests on non-granted lanes have no effect during BUSY.
- After each `ack`, a requester presents its next word or drops `req` in the following cycle.
- Reset asserted mid-burst clears all state immediately and asynchronously. The in-flight word is not acknowledged.

## Timing
- `req` sampled high at edge N in IDLE: gnt/sel are valid after edge N, and `dout_valid` can be high in cycle N+1. Arbitration latency is 1 cycle.
- Back-to-back words within a grant: 1 word per cycle while `dout_ready`=1.
- Release to next grant: exactly one IDLE cycle with gnt=0000, dout_valid=0.
- Worst-case wait for a continuously requesting lane: 3 × (MAX_HOLD + 1) cycles plus downstream stall cycles.
- Simultaneous release and new requests: arbitration uses the updated ptr in the following IDLE cycle.
- `dout`, `dout_valid`, and `ack` are combinational from registers, `req`, `data`, and `dout_ready`. There is no combinational path from `dout_ready` to `dout`.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Lane 0 is highest and lane 3 lowest. ptr is held at 0 and never updated. MAX_HOLD release still applies.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: drive rst_n=0 mid-burst with req=1111 and dout_ready=1. Expect gnt=0000, sel=00, dout_valid=0, dout=0, ack=0000 immediately (asynchronous). After release, the first grant goes to lane 0.
- Round-robin: set req=1111 constantly, MAX_HOLD=4, dout_ready=1, data lane i = 8'hA0+i.
  - Expect 4 words each from lanes 0,1,2,3,0 in that order.
  - Expect one bubble cycle between grants.
  - Expect dout values A0..A3 in lane order.
- Early drop: lane 2 alone requests, then drops req after 2 acks. Expect release on the next cycle, cnt=0, ptr=3, and one IDLE cycle. A subsequent req=0011 is granted to lane 0.
- Backpressure: lane 1 is granted and dout_ready=0 for 5 cycles. Expect gnt=0010, dout_valid=1, dout stable, ack=0000, and cnt unchanged. After dout_ready=1, exactly MAX_HOLD acks follow.
- MAX_HOLD=1 with req=1001: expect grant order 0,3,0,3, one word per grant.
- ARB_FIXED_PRIO_EN defined, req=1111: expect grants 0,0,0 repeating (lane 0 every grant, MAX_HOLD words each). Lane 3 is never granted while req[0]=1.
